// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared encodings and pipeline register layouts for the memory stage
package rv_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam logic [1:0] RU_ALU = 2'b00;
  localparam logic [1:0] RU_MEM = 2'b01;
  localparam logic [1:0] RU_PC4 = 2'b10;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_res;
    logic [31:0] rs2;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        dm_write;
    logic [2:0]  dm_ctrl;
    logic [1:0]  ru_src;
    logic        ru_write;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_res;
    logic [31:0] dm_data;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [1:0]  ru_src;
    logic        ru_write;
    logic        misalign;
  } mem_wb_t;

  // dm_ctrl[1:0] carries the access size; unused size codes behave as a word
  function automatic logic is_misaligned(input logic [2:0] dm_ctrl, input logic [1:0] a);
    logic m;
    case (dm_ctrl[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for stores and lane select/extension for loads
module load_store_align
  import rv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] lane;

  always_comb begin
    lane      = rdata >> {addr_lo, 3'b000};
    misalign  = is_misaligned(dm_ctrl, addr_lo);
    be        = 4'b1111;
    wdata     = rs2;
    load_data = lane;
    case (dm_ctrl)
      DM_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2[7:0]}};
        load_data = {{24{lane[7]}}, lane[7:0]};
      end
      DM_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2[7:0]}};
        load_data = {24'b0, lane[7:0]};
      end
      DM_H: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{rs2[15:0]}};
        load_data = {{16{lane[15]}}, lane[15:0]};
      end
      DM_HU: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{rs2[15:0]}};
        load_data = {16'b0, lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM register, data-memory handshake FSM and MEM/WB register
module ex_mem_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validIn,
  input  logic            flushIn,
  input  logic [XLEN-1:0] alu_resIn,
  input  logic [XLEN-1:0] RS2In,
  input  logic [XLEN-1:0] incrementPCIn,
  input  logic [4:0]      rdIn,
  input  logic            dm_writeIn,
  input  logic [2:0]      dm_ctrlIn,
  input  logic [1:0]      ru_data_srcIn,
  input  logic            ru_writeIn,
  output logic            stallOut,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            validOut,
  output logic [XLEN-1:0] alu_resOut,
  output logic [XLEN-1:0] dm_dataOut,
  output logic [XLEN-1:0] incrementPCOut,
  output logic [4:0]      rdOut,
  output logic [1:0]      ru_data_srcOut,
  output logic            ru_writeOut,
  output logic            misalignOut
);

  mem_state_t state_q, state_d;
  ex_mem_t    ex_q, ex_d;
  mem_wb_t    wb_q, wb_d;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        misalign;
  logic        mem_op;
  logic        ack_now;
  logic        in_valid;
  logic        in_mem_op;

  load_store_align u_align (
    .addr_lo   (ex_q.alu_res[1:0]),
    .dm_ctrl   (ex_q.dm_ctrl),
    .rs2       (ex_q.rs2),
    .rdata     (dmem_rdata),
    .be        (be),
    .wdata     (wdata),
    .load_data (load_data),
    .misalign  (misalign)
  );

  always_comb begin
    mem_op    = ex_q.valid & (ex_q.dm_write | (ex_q.ru_src == RU_MEM));
    ack_now   = (state_q == REQ) & dmem_ack;
    stallOut  = (state_q == REQ) & ~dmem_ack;
    in_valid  = validIn & ~flushIn;
    // misaligned ops never enter REQ; they retire in one cycle flagged
    in_mem_op = in_valid & (dm_writeIn | (ru_data_srcIn == RU_MEM))
              & ~is_misaligned(dm_ctrlIn, alu_resIn[1:0]);

    ex_d    = ex_q;
    state_d = state_q;
    if (!stallOut) begin
      ex_d.valid    = in_valid;
      ex_d.alu_res  = alu_resIn;
      ex_d.rs2      = RS2In;
      ex_d.pc4      = incrementPCIn;
      ex_d.rd       = rdIn;
      ex_d.dm_write = dm_writeIn;
      ex_d.dm_ctrl  = dm_ctrlIn;
      ex_d.ru_src   = ru_data_srcIn;
      ex_d.ru_write = ru_writeIn;
      state_d       = in_mem_op ? REQ : IDLE;
    end

    wb_d = '0;
    if (!stallOut) begin
      wb_d.valid    = ex_q.valid;
      wb_d.alu_res  = ex_q.alu_res;
      wb_d.dm_data  = ack_now ? load_data : 32'b0;
      wb_d.pc4      = ex_q.pc4;
      wb_d.rd       = ex_q.rd;
      wb_d.ru_src   = ex_q.ru_src;
      wb_d.ru_write = ex_q.valid & ex_q.ru_write & ~ex_q.dm_write & ~(mem_op & misalign);
      wb_d.misalign = mem_op & misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ex_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
    end
  end

  assign dmem_req       = (state_q == REQ);
  assign dmem_we        = dmem_req & ex_q.dm_write;
  assign dmem_addr      = {ex_q.alu_res[31:2], 2'b00};
  assign dmem_wdata     = wdata;
  assign dmem_be        = dmem_req ? be : 4'b0000;

  assign validOut       = wb_q.valid;
  assign alu_resOut     = wb_q.alu_res;
  assign dm_dataOut     = wb_q.dm_data;
  assign incrementPCOut = wb_q.pc4;
  assign rdOut          = wb_q.rd;
  assign ru_data_srcOut = wb_q.ru_src;
  assign ru_writeOut    = wb_q.ru_write;
  assign misalignOut    = wb_q.misalign;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized bench for ex_mem_stage against a transaction-level model
module tb_ex_mem_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        validIn, flushIn, dm_writeIn, ru_writeIn;
  logic [31:0] alu_resIn, RS2In, incrementPCIn;
  logic [4:0]  rdIn;
  logic [2:0]  dm_ctrlIn;
  logic [1:0]  ru_data_srcIn;
  logic        stallOut, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        validOut, ru_writeOut, misalignOut;
  logic [31:0] alu_resOut, dm_dataOut, incrementPCOut;
  logic [4:0]  rdOut;
  logic [1:0]  ru_data_srcOut;

  ex_mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .flushIn(flushIn),
    .alu_resIn(alu_resIn), .RS2In(RS2In), .incrementPCIn(incrementPCIn),
    .rdIn(rdIn), .dm_writeIn(dm_writeIn), .dm_ctrlIn(dm_ctrlIn),
    .ru_data_srcIn(ru_data_srcIn), .ru_writeIn(ru_writeIn), .stallOut(stallOut),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .validOut(validOut), .alu_resOut(alu_resOut),
    .dm_dataOut(dm_dataOut), .incrementPCOut(incrementPCOut), .rdOut(rdOut),
    .ru_data_srcOut(ru_data_srcOut), .ru_writeOut(ru_writeOut), .misalignOut(misalignOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [31:0] addr;
    bit [31:0] rs2;
    bit [31:0] pc4;
    bit [4:0]  rd;
    bit        wr;
    bit [2:0]  ctrl;
    bit [1:0]  src;
    bit        rw;
  } instr_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  instr_t    in_i;
  bit        in_flush;
  int        flush_mode;
  int        lat_mode;
  bit        rdata_fix_en;
  bit [31:0] rdata_fix;
  instr_t    m;
  int        lat_left;
  bit [31:0] m_rdata;
  bit        s_req, s_we, s_stall_e;
  bit [3:0]  s_be;
  bit [31:0] s_wdata;
  int        stall_cnt;

  function automatic int size_of(bit [2:0] c);
    return (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mem(instr_t x);
    return x.v && (x.wr || x.src == 2'b01);
  endfunction

  function automatic bit misal(instr_t x);
    return (int'(x.addr[1:0]) % size_of(x.ctrl)) != 0;
  endfunction

  function automatic bit [3:0] exp_be(instr_t x);
    int sz  = size_of(x.ctrl);
    int off = int'(x.addr[1:0]);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic bit [31:0] exp_wdata(instr_t x);
    bit [31:0] r;
    int sz = size_of(x.ctrl);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = x.rs2[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic bit [31:0] exp_load(instr_t x, bit [31:0] rdat);
    bit [63:0] v;
    int sz = size_of(x.ctrl);
    v = 64'(rdat) >> (8 * int'(x.addr[1:0]));
    v = v & ((64'd1 << (8 * sz)) - 64'd1);
    if (!x.ctrl[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic instr_t mk(bit v, bit [31:0] addr, bit [31:0] rs2, bit [4:0] rd,
                                bit wr, bit [2:0] ctrl, bit [1:0] src, bit rw);
    instr_t x;
    x.v = v; x.addr = addr; x.rs2 = rs2; x.pc4 = $urandom; x.rd = rd;
    x.wr = wr; x.ctrl = ctrl; x.src = src; x.rw = rw;
    return x;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    bit [2:0] ld_ctrl [5] = '{DM_B, DM_H, DM_W, DM_BU, DM_HU};
    x.v    = ($urandom_range(0, 7) != 0);
    x.wr   = ($urandom_range(0, 3) == 0);
    x.ctrl = x.wr ? ld_ctrl[$urandom_range(0, 2)] : ld_ctrl[$urandom_range(0, 4)];
    x.src  = x.wr ? (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10) : 2'($urandom_range(0, 2));
    x.addr = $urandom;
    x.rs2  = $urandom;
    x.pc4  = $urandom;
    x.rd   = 5'($urandom);
    x.rw   = 1'($urandom);
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_in();
    validIn = in_i.v; flushIn = in_flush; alu_resIn = in_i.addr; RS2In = in_i.rs2;
    incrementPCIn = in_i.pc4; rdIn = in_i.rd; dm_writeIn = in_i.wr; dm_ctrlIn = in_i.ctrl;
    ru_data_srcIn = in_i.src; ru_writeIn = in_i.rw;
  endtask

  // One clock: the model decides whether the memory op in flight finishes this cycle
  task automatic step();
    bit memop, req_e, ack, stall_e, exp_v, exp_mis, exp_rw;
    memop   = is_mem(m);
    req_e   = memop && !misal(m);
    ack     = req_e && (lat_left == 0);
    stall_e = req_e && !ack;
    case (flush_mode)
      1: in_flush = stall_e;
      2: in_flush = ($urandom_range(0, 7) == 0);
      default: ;
    endcase
    drive_in();
    dmem_ack   = ack;
    dmem_rdata = ack ? m_rdata : $urandom;
    #1;
    chk("stall", 32'(stallOut), 32'(stall_e));
    chk("req", 32'(dmem_req), 32'(req_e));
    if (req_e) begin
      chk("we", 32'(dmem_we), 32'(m.wr));
      chk("addr", dmem_addr, {m.addr[31:2], 2'b00});
      if (m.wr) begin
        chk("be", 32'(dmem_be), 32'(exp_be(m)));
        chk("wdata", dmem_wdata, exp_wdata(m));
      end
    end
    s_req = dmem_req; s_we = dmem_we; s_be = dmem_be; s_wdata = dmem_wdata; s_stall_e = stall_e;
    if (stallOut) stall_cnt++;
    exp_v   = !stall_e && m.v;
    exp_mis = !stall_e && memop && misal(m);
    exp_rw  = exp_v && m.rw && !m.wr && !exp_mis;
    @(posedge clk); #1;
    chk("validOut", 32'(validOut), 32'(exp_v));
    chk("ru_writeOut", 32'(ru_writeOut), 32'(exp_rw));
    chk("misalignOut", 32'(misalignOut), 32'(exp_mis));
    if (exp_v) begin
      chk("alu_resOut", alu_resOut, m.addr);
      chk("pc4Out", incrementPCOut, m.pc4);
      chk("rdOut", 32'(rdOut), 32'(m.rd));
      chk("ru_srcOut", 32'(ru_data_srcOut), 32'(m.src));
      if (req_e && !m.wr) chk("dm_dataOut", dm_dataOut, exp_load(m, m_rdata));
    end
    if (!stall_e) begin
      m        = in_i;
      m.v      = in_i.v && !in_flush;
      lat_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      m_rdata  = rdata_fix_en ? rdata_fix : $urandom;
    end else begin
      lat_left--;
    end
  endtask

  // Upstream presents an instruction and holds it while the stage stalls
  task automatic send(instr_t x);
    int guard = 0;
    in_i = x;
    stall_cnt = 0;
    step();
    while (s_stall_e && guard < 40) begin
      step();
      guard++;
    end
    if (s_stall_e) begin
      n_tests++; n_fail++;
      $display("FAIL stall_bound: stall still pending after %0d cycles", guard);
    end
  endtask

  instr_t nop;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nop = mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, DM_W, 2'b00, 1'b0);
    in_i = nop; in_flush = 1'b0; flush_mode = 0; lat_mode = 0;
    rdata_fix_en = 1'b1; rdata_fix = 32'h0;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stallOut), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_valid", 32'(validOut), 32'h0);
    chk("rst_ruw", 32'(ru_writeOut), 32'h0);
    chk("rst_mis", 32'(misalignOut), 32'h0);
    chk("rst_alu", alu_resOut, 32'h0);
    rst = 1'b0;
    m = nop; lat_left = 0; m_rdata = 32'h0;

    // LW 0x100, ack in first REQ cycle
    rdata_fix = 32'hDEADBEEF;
    send(mk(1'b1, 32'h100, 32'h0, 5'd5, 1'b0, DM_W, 2'b01, 1'b1));
    send(nop);
    chk("lw_stalls", 32'(stall_cnt), 32'd0);
    chk("lw_data", dm_dataOut, 32'hDEADBEEF);
    chk("lw_ruw", 32'(ru_writeOut), 32'h1);

    // LB 0x103, three wait cycles
    lat_mode = 3; rdata_fix = 32'h80FF0000;
    send(mk(1'b1, 32'h103, 32'h0, 5'd6, 1'b0, DM_B, 2'b01, 1'b1));
    lat_mode = 0;
    send(nop);
    chk("lb_stalls", 32'(stall_cnt), 32'd3);
    chk("lb_data", dm_dataOut, 32'hFFFFFF80);

    // SH 0x202
    lat_mode = 1;
    send(mk(1'b1, 32'h202, 32'h1234ABCD, 5'd7, 1'b1, DM_H, 2'b00, 1'b1));
    lat_mode = 0;
    send(nop);
    chk("sh_be", 32'(s_be), 32'h0000000C);
    chk("sh_wdata", s_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(s_we), 32'h1);
    chk("sh_ruw", 32'(ru_writeOut), 32'h0);

    // misaligned LW 0x101
    send(mk(1'b1, 32'h101, 32'h0, 5'd8, 1'b0, DM_W, 2'b01, 1'b1));
    send(nop);
    chk("mis_req", 32'(s_req), 32'h0);
    chk("mis_stalls", 32'(stall_cnt), 32'd0);
    chk("mis_flag", 32'(misalignOut), 32'h1);
    chk("mis_ruw", 32'(ru_writeOut), 32'h0);

    // LHU stalled with flush held high, then an unstalled flush
    lat_mode = 2;
    send(mk(1'b1, 32'h10, 32'h0, 5'd9, 1'b0, DM_HU, 2'b01, 1'b1));
    lat_mode = 0; flush_mode = 1;
    send(mk(1'b1, 32'h55, 32'h0, 5'd10, 1'b0, DM_W, 2'b00, 1'b1));
    chk("flush_stalls", 32'(stall_cnt), 32'd2);
    flush_mode = 0; in_flush = 1'b0;
    send(nop);
    chk("flush_kept_valid", 32'(validOut), 32'h1);
    chk("flush_kept_rd", 32'(rdOut), 32'd10);
    in_flush = 1'b1;
    send(mk(1'b1, 32'h66, 32'h0, 5'd11, 1'b0, DM_W, 2'b00, 1'b1));
    in_flush = 1'b0;
    send(nop);
    chk("flush_bubble_valid", 32'(validOut), 32'h0);
    chk("flush_bubble_ruw", 32'(ru_writeOut), 32'h0);

    // randomized traffic
    flush_mode = 2; lat_mode = -1; rdata_fix_en = 1'b0;
    for (int i = 0; i < 300; i++) send(rand_instr());

    // reset while a request waits for its ack
    flush_mode = 0; in_flush = 1'b0; lat_mode = 10;
    send(mk(1'b1, 32'h200, 32'h0, 5'd12, 1'b0, DM_W, 2'b01, 1'b1));
    lat_mode = 0;
    in_i = nop;
    step();
    rst = 1'b1; validIn = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("rreq_req", 32'(dmem_req), 32'h0);
    chk("rreq_stall", 32'(stallOut), 32'h0);
    chk("rreq_valid", 32'(validOut), 32'h0);
    chk("rreq_ruw", 32'(ru_writeOut), 32'h0);
    chk("rreq_dm", dm_dataOut, 32'h0);
    chk("rreq_rd", 32'(rdOut), 32'h0);
    chk("rreq_be", 32'(dmem_be), 32'h0);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = $urandom;
    #1;
    chk("late_ack_stall", 32'(stallOut), 32'h0);
    @(posedge clk); #1;
    chk("late_ack_req", 32'(dmem_req), 32'h0);
    chk("late_ack_valid", 32'(validOut), 32'h0);
    chk("late_ack_dm", dm_dataOut, 32'h0);
    dmem_ack = 1'b0;
    m = nop; lat_left = 0;
    flush_mode = 2; lat_mode = -1;
    for (int i = 0; i < 40; i++) send(rand_instr());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
